// File: rtl/dlatch_bank_pkg.sv
// Shared mode encoding and counter helpers for the dlatch_bank channels.
package dlatch_bank_pkg;

    typedef enum logic [1:0] {
        TRANSP = 2'b00,
        EDGE   = 2'b01,
        FALL   = 2'b10,
        HOLD   = 2'b11
    } mode_e;

    // All-ones value of a w-bit counter, used as the saturation ceiling.
    function automatic logic [63:0] cnt_sat(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/dlatch_channel.sv
// One storage channel: held data, delayed enable, saturating capture count and sticky valid.
module dlatch_channel
    import dlatch_bank_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  mode_e            mode,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [CNT_W-1:0] cap_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat(CNT_W));

    logic [WIDTH-1:0] held;
    logic             en_q;
    logic [CNT_W-1:0] cnt;
    logic             vld;
    logic             cap;

    // Capture event decode; FALL fires on the cycle en is first seen low.
    always_comb begin
        cap = 1'b0;
        case (mode)
            TRANSP:  cap = en;
            EDGE:    cap = en;
            FALL:    cap = en_q & ~en;
            HOLD:    cap = 1'b0;
            default: cap = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held <= '0;
            en_q <= 1'b0;
            cnt  <= '0;
            vld  <= 1'b0;
        end else begin
            en_q <= en;
            if (cap) begin
                held <= d;
                vld  <= 1'b1;
            end
            // Clear wins over a coincident capture.
            if (clr_cnt) begin
                cnt <= '0;
            end else if (cap && (cnt != CNT_MAX)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Transparent mode passes d straight through while enabled; reset forces zero.
    always_comb begin
        q = held;
        if (rst) begin
            q = '0;
        end else if ((mode == TRANSP) && en) begin
            q = d;
        end
    end

    assign q_valid = vld;
    assign cap_cnt = cnt;

endmodule

// File: rtl/dlatch_bank.sv
// Multi-channel latch/register bank under one global mode.
module dlatch_bank
    import dlatch_bank_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic [CHANNELS-1:0]       en,
    input  logic [1:0]                mode,
    input  logic                      clr_cnt,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       q_valid,
    output logic [CHANNELS*CNT_W-1:0] cap_cnt
);

    mode_e mode_dec;

    assign mode_dec = mode_e'(mode);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        dlatch_channel #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .d       (d[i*WIDTH +: WIDTH]),
            .en      (en[i]),
            .mode    (mode_dec),
            .clr_cnt (clr_cnt),
            .q       (q[i*WIDTH +: WIDTH]),
            .q_valid (q_valid[i]),
            .cap_cnt (cap_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: doc/dlatch_bank.md
Name: dlatch_bank

Overview:
- Parametrised, multi-channel successor to the single-bit D latch user project.
- CHANNELS independent WIDTH-bit storage channels under one global mode:
  - transparent latch (synchronous emulation, no inferred latches)
  - edge-enabled register
  - capture-on-enable-fall
  - freeze
- Each channel has a saturating capture counter and a sticky valid flag.
- Sits behind the TinyTapeout ui_in/uo_out wrapper; the wrapper maps pins onto d, en and mode.

Parameters:
- WIDTH, 8, data bits per channel (>=1)
- CHANNELS, 2, number of independent channels (>=1)
- CNT_W, 8, capture-counter width per channel (>=2)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- d  in  CHANNELS*WIDTH  channel data, channel i at bits [i*WIDTH +: WIDTH]
- en  in  CHANNELS  per-channel enable
- mode  in  2  global mode: 00 TRANSP, 01 EDGE, 10 FALL, 11 HOLD
- clr_cnt  in  1  synchronous clear of all capture counters
- q  out  CHANNELS*WIDTH  channel outputs
- q_valid  out  CHANNELS  sticky: channel has captured at least once
- cap_cnt  out  CHANNELS*CNT_W  per-channel capture count, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Per-channel state:
  - held[WIDTH]
  - en_q (en delayed one cycle)
  - cnt[CNT_W]
  - vld
- Reset (asynchronous, immediate, any mode): held=0, en_q=0, cnt=0, vld=0.
  - While rst=1: q=0 in all modes, including TRANSP with en=1.
  - Reset asserted mid-operation discards in-flight captures.
- en_q <= en every cycle in every mode, so FALL edge detection is correct right after a mode switch.
- Capture event cap_i per mode:
  - TRANSP: cap = en
  - EDGE: cap = en
  - FALL: cap = en_q & ~en; captured data is d sampled in the cycle en is low
  - HOLD: cap = 0 (en ignored, state frozen)
- On cap_i at a clock edge: held <= d_i and vld <= 1.
- Output q_i:
  - TRANSP: q = en ? d (combinational, zero latency) : held. held tracks d each enabled cycle, so q holds the last enabled-cycle value when en drops.
  - EDGE / FALL / HOLD: q = held. Registered output, 1-cycle latency from capture.
- Counter:
  - On cap_i, cnt increments and saturates at 2^CNT_W-1 (no wrap).
  - clr_cnt=1 forces cnt=0 for all channels. It wins over a simultaneous capture: the result is 0, not 1.
  - clr_cnt does not affect held or vld.
- vld is cleared only by rst.
- Mode change takes effect the same cycle mode changes; no pipeline in mode decode.
  - Switching TRANSP->HOLD with en=1 freezes q at the held value (last clocked d), not the live d.
- Channels are fully independent; simultaneous events on different channels do not interact.
- mode is a shared decode; there are no per-channel modes.
- No X propagation from unused modes; all four encodings are defined.

Decomposition:
- Package dlatch_bank_pkg:
  - mode_e enum: TRANSP=2'b00, EDGE=2'b01, FALL=2'b10, HOLD=2'b11
  - function returning the saturation value for CNT_W
- Sub-module dlatch_channel, one per channel, instantiated in a generate loop.
  - Contains held, en_q, cnt, vld and the q mux.
  - Parameters: WIDTH, CNT_W.
- Top level:
  - slices the buses
  - broadcasts the decoded mode and clr_cnt
  - concatenates the outputs

Test Plan:
- Reset: assert rst mid-run with mode=TRANSP, en=1, d=8'hA5 -> q=0, q_valid=0, cap_cnt=0 immediately (before next clk); release -> q=8'hA5 combinationally.
- TRANSP hold: en=1, d changes 8'h11 then 8'h22 on successive cycles; en->0, then d=8'h33 -> q stays 8'h22; cap_cnt=2.
- EDGE latency: mode=EDGE, en=1 for one cycle with d=8'h5C -> q=8'h5C on the following cycle (not same cycle); cap_cnt=1; q_valid=1.
- FALL: mode=FALL, en high 3 cycles (d=8'h01..03), drops with d=8'h7E in the low cycle -> q=8'h7E after that edge; cap_cnt=1. Mode switched to FALL while en already high then dropping -> still captures once.
- Saturation and clear: CNT_W=2, 5 captures -> cap_cnt=3. clr_cnt coincident with a capture -> cap_cnt=0 while held updates. HOLD mode with en toggling -> no change in q or cap_cnt.
- Channel independence: CHANNELS=2, channel 0 en=1 d=8'hF0, channel 1 en=0 -> q[15:8] unchanged, q_valid=2'b01.
